fpmul_scheduler: RTL and testbench

FPMUL_SCHEDULER -- requirements
Module: fpmul_scheduler

---
 rtl/fpmul_scheduler.sv | 154 +++++++++++++++
 tb/tb_fpmul_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_scheduler.sv
// fpmul_scheduler
//   Arbitrates two requesters onto one FP multiplier pipeline of latency LAT.
//   The bench does not need this header; it documents the block's behaviour.
//   - A request is accepted when reqN_valid & reqN_ready. At most one request
//     is accepted per cycle.
//   - The accepted operands are registered onto mul_a/mul_b, and mul_valid is
//     strobed for one cycle.
//   - A valid+id tag travels LAT stages behind mul_valid. This lines the tag up
//     with mul_result. The product is then registered onto the tagged
//     requester's rspN_data and rspN_valid is pulsed.
//
// Configuration macro: FPMUL_SCHED_RR_EN
//   defined   -> round-robin arbitration on contention
//   undefined -> fixed priority, requester 0 wins
//
// Ports
//   clk, rst (sync, active-high)
//   req0_valid/req0_ready/req0_a/req0_b   requester 0 operand handshake
//   req1_valid/req1_ready/req1_a/req1_b   requester 1 operand handshake
//   hold                                  blocks new issue, in-flight ops complete
//   mul_a/mul_b/mul_valid                 issue to multiplier pipeline
//   mul_result                            product, LAT cycles after mul_valid
//   rsp0_valid/rsp0_data                  requester 0 result strobe
//   rsp1_valid/rsp1_data                  requester 1 result strobe
//   inflight                              ops accepted but not yet responded
//   idle                                  nothing in flight, nothing accepted
module fpmul_scheduler #(
  parameter int unsigned LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        hold,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_valid,
  input  logic [31:0] mul_result,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic [3:0]  inflight,
  output logic        idle
);

  logic           grant_id;
  logic           accept;
  logic           mul_valid_q;
  logic           mul_id_q;
  logic [31:0]    mul_a_q;
  logic [31:0]    mul_b_q;
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_id;
  logic           rsp0_valid_q;
  logic           rsp1_valid_q;
  logic [31:0]    rsp0_data_q;
  logic [31:0]    rsp1_data_q;
  logic [3:0]     inflight_q;
  logic           rsp_done;
  logic           tag_hit0;
  logic           tag_hit1;

`ifdef FPMUL_SCHED_RR_EN
  // rr_ptr names the requester that wins the next contention.
  logic rr_ptr;

  always_comb grant_id = (req0_valid & req1_valid) ? rr_ptr : ~req0_valid;

  always_ff @(posedge clk) begin
    if (rst)         rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= ~grant_id;
  end
`else
  always_comb grant_id = ~req0_valid;
`endif

  assign req0_ready = ~rst & ~hold & req0_valid & ~grant_id;
  assign req1_ready = ~rst & ~hold & req1_valid &  grant_id;
  assign accept     = req0_ready | req1_ready;

  // Issue stage
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_valid_q <= 1'b0;
      mul_id_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      mul_valid_q <= accept;
      if (accept) begin
        mul_id_q <= grant_id;
        mul_a_q  <= grant_id ? req1_a : req0_a;
        mul_b_q  <= grant_id ? req1_b : req0_b;
      end
    end
  end

  // Tag pipeline: stage LAT-1 lines up with mul_result
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[LAT-2:0], mul_valid_q};
      tag_id <= {tag_id[LAT-2:0], mul_id_q};
    end
  end

  assign tag_hit0 = tag_v[LAT-1] & ~tag_id[LAT-1];
  assign tag_hit1 = tag_v[LAT-1] &  tag_id[LAT-1];

  // Response stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      rsp0_valid_q <= tag_hit0;
      rsp1_valid_q <= tag_hit1;
      if (tag_hit0) rsp0_data_q <= mul_result;
      if (tag_hit1) rsp1_data_q <= mul_result;
    end
  end

  assign rsp_done = rsp0_valid_q | rsp1_valid_q;

  always_ff @(posedge clk) begin
    if (rst)                       inflight_q <= '0;
    else if (accept & ~rsp_done)   inflight_q <= inflight_q + 4'd1;
    else if (~accept & rsp_done)   inflight_q <= inflight_q - 4'd1;
  end

  // Outputs are masked while rst is high. Reset values therefore show in the
  // same cycle rst is sampled, not one cycle later.
  assign mul_valid  = ~rst & mul_valid_q;
  assign mul_a      = rst ? '0 : mul_a_q;
  assign mul_b      = rst ? '0 : mul_b_q;
  assign rsp0_valid = ~rst & rsp0_valid_q;
  assign rsp1_valid = ~rst & rsp1_valid_q;
  assign rsp0_data  = rst ? '0 : rsp0_data_q;
  assign rsp1_data  = rst ? '0 : rsp1_data_q;
  assign inflight   = rst ? '0 : inflight_q;
  assign idle       = (inflight == 4'd0) & ~accept;

endmodule

// File: tb/tb_fpmul_scheduler.sv
module tb_fpmul_scheduler;
  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready, hold;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] mul_a, mul_b, mul_result;
  logic        mul_valid;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic [3:0]  inflight;
  logic        idle;

  int checks = 0;
  int errors = 0;

  fpmul_scheduler #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .hold(hold), .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid), .mul_result(mul_result),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .inflight(inflight), .idle(idle)
  );

  always #5 clk = ~clk;

  // Conversions between single and double precision for normal, exactly
  // representable values.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'h0;
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  // Stand-in multiplier pipeline. Outputs garbage when no op is present.
  logic [31:0] pipe [LAT];
  initial for (int i = 0; i < int'(LAT); i++) pipe[i] = '0;
  always @(posedge clk) begin
    for (int i = int'(LAT) - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= mul_valid ? fmul(mul_a, mul_b) : $urandom;
  end
  assign mul_result = pipe[LAT-1];

  // Reference model. It keeps a queue of expected responses, each with its
  // due cycle, and is evaluated mid-cycle.
  typedef struct { int id; logic [31:0] data; int due; } exp_t;
  exp_t        q[$];
  int          cyc = 0;
  int          last_acc = -10;
  logic        m_ptr = 1'b0;
  logic [31:0] last_a, last_b;
  logic        e_r0, e_r1, e_mv, e_idle;
  logic [31:0] e_ma, e_mb;
  logic        e_rv [2];
  logic [31:0] e_rd [2];
  int          e_inf;

  always @(negedge clk) begin
    logic pref0;
    int   win;
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      m_ptr = 1'b0; e_r0 = 0; e_r1 = 0; e_mv = 0; e_ma = '0; e_mb = '0;
      e_rv[0] = 0; e_rv[1] = 0; e_rd[0] = '0; e_rd[1] = '0;
      e_inf = 0; e_idle = 1; last_acc = -10;
    end else begin
      e_rv[0] = 0; e_rv[1] = 0;
      e_inf = q.size();
      if (q.size() > 0 && q[0].due == cyc) begin
        e_rv[q[0].id] = 1;
        e_rd[q[0].id] = q[0].data;
        void'(q.pop_front());
      end
      e_mv = (last_acc == cyc - 1);
      if (e_mv) begin e_ma = last_a; e_mb = last_b; end
`ifdef FPMUL_SCHED_RR_EN
      pref0 = (m_ptr == 1'b0);
`else
      pref0 = 1'b1;
`endif
      win = -1;
      if (!hold) begin
        if (req0_valid && req1_valid) win = pref0 ? 0 : 1;
        else if (req0_valid)          win = 0;
        else if (req1_valid)          win = 1;
      end
      e_r0 = (win == 0);
      e_r1 = (win == 1);
      if (win >= 0) begin
        last_a = (win == 0) ? req0_a : req1_a;
        last_b = (win == 0) ? req0_b : req1_b;
        e.id = win; e.data = fmul(last_a, last_b); e.due = cyc + 2 + int'(LAT);
        q.push_back(e);
        last_acc = cyc;
        m_ptr = (win == 0);
      end
      e_idle = (e_inf == 0) && (win < 0);
    end
  end

  task automatic to_drive();
    @(posedge clk); #1;
  endtask

  task automatic to_sample();
    @(negedge clk); #1;
  endtask

  task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic h);
    rst = 0; req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1; hold = h;
  endtask

  task automatic apply_reset();
    repeat (2) begin
      to_drive();
      drive(0, '0, '0, 0, '0, '0, 0);
      rst = 1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      to_drive();
      rst = 1; req0_valid = 1; req1_valid = 1; hold = 0;
      req0_a = 32'h3F800000; req0_b = 32'h3F800000; req1_a = 32'h40000000; req1_b = 32'h40000000;
      to_sample();
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", {req0_ready, req1_ready}); end
      checks++; if ({mul_valid, rsp0_valid, rsp1_valid} !== 3'b000) begin errors++; $display("FAIL rst_valids got=%b exp=000", {mul_valid, rsp0_valid, rsp1_valid}); end
      checks++; if (inflight !== 4'd0 || idle !== 1'b1) begin errors++; $display("FAIL rst_inflight_idle got=%0d/%b exp=0/1", inflight, idle); end
      checks++; if ({mul_a, mul_b, rsp0_data, rsp1_data} !== 128'd0) begin errors++; $display("FAIL rst_data got=%h %h %h %h exp=0", mul_a, mul_b, rsp0_data, rsp1_data); end
    end
    to_drive();
    drive(1, 32'h3F800000, 32'h3F800000, 0, '0, '0, 0);
    to_sample();
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rst_first_accept got=%b exp=10", {req0_ready, req1_ready}); end
  endtask

  task automatic test_single();
    apply_reset();
    for (int i = 0; i <= 8; i++) begin
      to_drive();
      if (i == 0) drive(1, 32'h3FC00000, 32'h40000000, 0, '0, '0, 0);
      else        drive(0, '0, '0, 0, '0, '0, 0);
      to_sample();
      if (i == 0) begin
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", req0_ready); end
      end
      if (i == 1) begin
        checks++; if (mul_valid !== 1'b1 || mul_a !== 32'h3FC00000 || mul_b !== 32'h40000000) begin
          errors++; $display("FAIL single_issue got=%b %h %h exp=1 3fc00000 40000000", mul_valid, mul_a, mul_b); end
      end
      checks++; if (rsp0_valid !== (i == 6)) begin errors++; $display("FAIL single_rsp0_valid i=%0d got=%b exp=%b", i, rsp0_valid, i == 6); end
      checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp1_valid i=%0d got=%b exp=0", i, rsp1_valid); end
      if (i == 6) begin
        checks++; if (rsp0_data !== 32'h40400000) begin errors++; $display("FAIL single_rsp0_data got=%h exp=40400000", rsp0_data); end
      end
    end
  endtask

  task automatic test_contention();
    int order[4];
    int seen[$];
    int peak = 0;
    int g;
    apply_reset();
    for (int i = 0; i <= 12; i++) begin
      to_drive();
`ifdef FPMUL_SCHED_RR_EN
      drive(i < 4, r2f(real'(i + 1)), r2f(3.0), i < 4, r2f(real'(i + 1)), r2f(5.0), 0);
`else
      drive(i < 3, r2f(real'(i + 1)), r2f(3.0), i < 4, r2f(real'(i + 1)), r2f(5.0), 0);
`endif
      to_sample();
      if (i < 4) begin
`ifdef FPMUL_SCHED_RR_EN
        g = i % 2;
`else
        g = (i < 3) ? 0 : 1;
`endif
        order[i] = g;
        checks++; if ({req0_ready, req1_ready} !== {g == 0, g == 1}) begin
          errors++; $display("FAIL cont_grant i=%0d got=%b%b exp_grant=%0d", i, req0_ready, req1_ready, g); end
      end
      if (int'(inflight) > peak) peak = int'(inflight);
      checks++; if ((rsp0_valid | rsp1_valid) !== (i >= 6 && i <= 9)) begin
        errors++; $display("FAIL cont_rsp_timing i=%0d got=%b%b", i, rsp0_valid, rsp1_valid); end
      checks++; if (rsp0_valid !== e_rv[0] || rsp1_valid !== e_rv[1] || rsp0_data !== e_rd[0] || rsp1_data !== e_rd[1]) begin
        errors++; $display("FAIL cont_rsp i=%0d got=%b%b %h %h exp=%b%b %h %h", i, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, e_rv[0], e_rv[1], e_rd[0], e_rd[1]); end
      if (rsp0_valid) seen.push_back(0);
      if (rsp1_valid) seen.push_back(1);
    end
    checks++; if (seen.size() != 4) begin errors++; $display("FAIL cont_rsp_count got=%0d exp=4", seen.size()); end
    for (int j = 0; j < 4 && j < seen.size(); j++) begin
      checks++; if (seen[j] != order[j]) begin errors++; $display("FAIL cont_order j=%0d got=%0d exp=%0d", j, seen[j], order[j]); end
    end
    checks++; if (peak != 4) begin errors++; $display("FAIL cont_peak_inflight got=%0d exp=4", peak); end
  endtask

  task automatic test_hold();
    int pulses = 0;
    apply_reset();
    for (int i = 0; i <= 10; i++) begin
      to_drive();
      if (i == 0)      drive(1, r2f(2.0), r2f(3.0), 0, '0, '0, 0);
      else if (i == 1) drive(0, '0, '0, 1, r2f(4.0), r2f(5.0), 0);
      else             drive(1, r2f(7.0), r2f(7.0), 1, r2f(9.0), r2f(9.0), 1);
      to_sample();
      if (i >= 2) begin
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL hold_ready i=%0d got=%b%b exp=00", i, req0_ready, req1_ready); end
      end
      if (rsp0_valid) begin
        pulses++;
        checks++; if (i != 6 || rsp0_data !== r2f(6.0)) begin errors++; $display("FAIL hold_rsp0 i=%0d data=%h exp i=6 data=%h", i, rsp0_data, r2f(6.0)); end
      end
      if (rsp1_valid) begin
        pulses++;
        checks++; if (i != 7 || rsp1_data !== r2f(20.0)) begin errors++; $display("FAIL hold_rsp1 i=%0d data=%h exp i=7 data=%h", i, rsp1_data, r2f(20.0)); end
      end
      if (i == 7 || i == 8) begin
        checks++; if (idle !== (i == 8)) begin errors++; $display("FAIL hold_idle i=%0d got=%b exp=%b", i, idle, i == 8); end
      end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL hold_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    for (int i = 0; i <= 14; i++) begin
      to_drive();
      if (i < 3) drive(1, r2f(real'(i + 2)), r2f(3.0), 0, '0, '0, 0);
      else       drive(0, '0, '0, 0, '0, '0, 0);
      if (i == 4) rst = 1;
      to_sample();
      if (i == 3) begin
        checks++; if (inflight !== 4'd3) begin errors++; $display("FAIL mid_inflight_pre got=%0d exp=3", inflight); end
      end
      if (i >= 4) begin
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL mid_rsp i=%0d got=%b%b exp=00", i, rsp0_valid, rsp1_valid); end
        checks++; if (inflight !== 4'd0 || idle !== 1'b1) begin errors++; $display("FAIL mid_idle i=%0d got=%0d/%b exp=0/1", i, inflight, idle); end
      end
    end
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      to_drive();
      if (i < 20) drive(0, '0, '0, 1, r2f(real'(i + 1)), r2f(2.0), 0);
      else        drive(0, '0, '0, 0, '0, '0, 0);
      to_sample();
      if (i < 20) begin
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, req1_ready); end
      end
      checks++; if (rsp1_valid !== (i >= 6 && i <= 25) || rsp0_valid !== 1'b0) begin
        errors++; $display("FAIL stream_valid i=%0d got=%b%b", i, rsp0_valid, rsp1_valid); end
      if (i >= 6 && i <= 25) begin
        checks++; if (rsp1_data !== r2f(2.0 * real'(i - 5))) begin
          errors++; $display("FAIL stream_data k=%0d got=%h exp=%h", i - 5, rsp1_data, r2f(2.0 * real'(i - 5))); end
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      to_drive();
      drive($urandom_range(0, 1) == 1, r2f(real'($urandom_range(1, 1000))), r2f(real'($urandom_range(1, 1000))),
            $urandom_range(0, 1) == 1, r2f(real'($urandom_range(1, 1000))), r2f(real'($urandom_range(1, 1000))),
            $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) rst = 1;
      to_sample();
      checks++; if (req0_ready !== e_r0 || req1_ready !== e_r1) begin
        errors++; $display("FAIL rnd_ready i=%0d got=%b%b exp=%b%b", i, req0_ready, req1_ready, e_r0, e_r1); end
      checks++; if (mul_valid !== e_mv || mul_a !== e_ma || mul_b !== e_mb) begin
        errors++; $display("FAIL rnd_issue i=%0d got=%b %h %h exp=%b %h %h", i, mul_valid, mul_a, mul_b, e_mv, e_ma, e_mb); end
      checks++; if (rsp0_valid !== e_rv[0] || rsp0_data !== e_rd[0]) begin
        errors++; $display("FAIL rnd_rsp0 i=%0d got=%b %h exp=%b %h", i, rsp0_valid, rsp0_data, e_rv[0], e_rd[0]); end
      checks++; if (rsp1_valid !== e_rv[1] || rsp1_data !== e_rd[1]) begin
        errors++; $display("FAIL rnd_rsp1 i=%0d got=%b %h exp=%b %h", i, rsp1_valid, rsp1_data, e_rv[1], e_rd[1]); end
      checks++; if (int'(inflight) != e_inf || idle !== e_idle || e_inf > int'(LAT) + 2) begin
        errors++; $display("FAIL rnd_inflight i=%0d got=%0d/%b exp=%0d/%b", i, inflight, idle, e_inf, e_idle); end
    end
  endtask

  initial begin
    rst = 1; hold = 0; req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_single();
    test_contention();
    test_hold();
    test_reset_midflight();
    test_stream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
